gpr_file: RTL and testbench
===========================

# gpr_file

General-purpose register file for the RV64 NPC decode stage. Holds NR_REG registers of XLEN bits, with two asynchronous read ports and one synchronous write port. The write port is addressed through a keyed one-hot decoder that hard-wires x0 to zero. It sits inside the IDU: it supplies rs1/rs2 operands and takes the execute-stage result as write data.

## Interface
- XLEN, 64, register width in bits
- NR_REG, 32, number of architectural registers
- REG_SEL, 5, register index width (log2 NR_REG)
- RESET_VAL, 0, value loaded into every register on reset

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, synchronous and active-high
- wen  in  1  global write enable
- rd  in  REG_SEL  write index
- wdata  in  XLEN  write data (execute result)
- rs1  in  REG_SEL  read index, port 1
- rs2  in  REG_SEL  read index, port 2
- rdata1  out  XLEN  value of register rs1
- rdata2  out  XLEN  value of register rs2
- gprs  out  NR_REG*XLEN  flattened view of all registers for the difftest/DPI hook; register i is at bits [i*XLEN +: XLEN]

## Operation
- Write decoder: a key/value lookup maps rd to an NR_REG-bit one-hot enable vector.
  - Entries 1..NR_REG-1 map key k to the value 1<<k.
  - Key 0 maps to all-zeros.
  - Any unmatched key yields all-zeros.
- Per-register enable is wen & onehot[i]. Register i captures wdata when its enable is high.
- x0 reads as RESET_VAL (0) at all times. Writes to rd=0 are discarded, whatever wen and wdata are.
- Reads are purely combinational: rdata1 = reg[rs1] and rdata2 = reg[rs2]. rs1 == rs2 is legal; both ports return the same value.
- There is no write-to-read bypass. While a write is pending, a read of the same index returns the old value until the clock edge.
- gprs always reflects the current register contents. It is combinational from the flops.

## Timing
- Write latency is 1 cycle. The new value is visible on rdata and gprs immediately after the rising edge where enable was high.
- Read latency is 0 cycles (combinational).
- Reset: if rst=1 at a rising edge, every register loads RESET_VAL. Reset takes priority over a simultaneous write.
- All outputs are 0 after reset.
- Reset asserted in the middle of a sequence clears all state at the next edge. Any write presented in that cycle is lost.
- wen=0 holds all registers, regardless of rd and wdata.
- rd values outside 0..NR_REG-1 cannot occur with REG_SEL=5. If NR_REG < 2^REG_SEL, such writes are dropped by the default-zero decoder output.

## Structure
- Shared package: XLEN, NR_REG, REG_SEL, and the reset constant.
- Sub-module 1: reuse ysyx_22050039_Reg for the storage cells, one per register, parameters (WIDTH, RESET_VAL), ports (clk, rst, din, dout, wen).
  - Sync reset has priority; otherwise it loads din when wen is high.
  - Register 0 is instantiated with a tied-low enable.
- Sub-module 2: reuse ysyx_22050039_MuxKey for the write decoder, parameters (NR_KEY, KEY_LEN, DATA_LEN).
  - lut is a flat concatenation of {key, data} pairs, with the first pair in the most-significant bits.
  - out is the data of the matching key, or 0 when no key matches.
- Register instances are generated with a generate loop over 1..NR_REG-1.

## Test plan
- Reset: set rst=1 for 1 cycle with wen=1, rd=5, wdata=0xFF → all gprs are 0 and rdata1 is 0 for rs1=5.
- Basic write/read: wen=1, rd=3, wdata=0xDEADBEEF_12345678 at edge N → rdata1 with rs1=3 shows that value after N. Before N it shows 0.
- x0 immutability: wen=1, rd=0, wdata=0xFFFF_FFFF_FFFF_FFFF → rdata1 with rs1=0 stays 0 and gprs[63:0] stays 0.
- Enable gating: wen=0, rd=7, wdata=0x55 → reg 7 is unchanged (0). Then wen=1 → reg 7 becomes 0x55, and the other registers are unchanged.
- No bypass / dual read: write 0xA to x10 at edge N. In the same cycle rs1=rs2=10 read the old value 0. After the edge both ports read 0xA.
- One-hot sweep: write value i+100 to each rd=1..31 on consecutive cycles → gprs slice i equals i+100 for all i, and slice 0 equals 0.

Source files
------------

// File: rtl/gpr_file_pkg.sv
// Shared constants for the decode-stage general-purpose register file.
// Sized for RV64: 32 architectural registers of 64 bits, x0 held at zero.
package gpr_file_pkg;
  localparam int XLEN    = 64;
  localparam int NR_REG  = 32;
  localparam int REG_SEL = 5;
  localparam logic [XLEN-1:0] RESET_VAL = '0;
endpackage

// File: rtl/ysyx_22050039_MuxKey.sv
// Key/value lookup: returns the data of the matching {key, data} pair, else zero.
// Latency: combinational; no backpressure. First pair sits in the lut MSBs.
module ysyx_22050039_MuxKey #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]                  out,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  // Keys are expected to be unique, so OR-combining the hits is exact.
  always_comb begin
    out = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut[(NR_KEY-1-i)*PAIR_LEN + DATA_LEN +: KEY_LEN] == key) begin
        out = out | lut[(NR_KEY-1-i)*PAIR_LEN +: DATA_LEN];
      end
    end
  end
endmodule

// File: rtl/ysyx_22050039_Reg.sv
// Single storage register with synchronous active-high reset and load enable.
// Latency: 1 cycle from din to dout; no backpressure; reset wins over wen.
module ysyx_22050039_Reg #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end
endmodule

// File: rtl/gpr_file.sv
// Register file: two combinational read ports, one write port decoded to one-hot.
// Latency: write visible 1 cycle after the edge, reads 0 cycles; no backpressure.
module gpr_file
  import gpr_file_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int NR_REG_P  = NR_REG,
  parameter int REG_SEL_P = REG_SEL,
  parameter logic [XLEN_P-1:0] RESET_VAL_P = RESET_VAL
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic [REG_SEL_P-1:0]       rd,
  input  logic [XLEN_P-1:0]          wdata,
  input  logic [REG_SEL_P-1:0]       rs1,
  input  logic [REG_SEL_P-1:0]       rs2,
  output logic [XLEN_P-1:0]          rdata1,
  output logic [XLEN_P-1:0]          rdata2,
  output logic [NR_REG_P*XLEN_P-1:0] gprs
);
  localparam int PAIR_LEN = REG_SEL_P + NR_REG_P;

  logic [NR_REG_P*PAIR_LEN-1:0] lut;
  logic [NR_REG_P-1:0]          onehot;
  logic [XLEN_P-1:0]            regs [NR_REG_P];
  logic                         unused_onehot0;

  // Key 0 decodes to no enable at all, which is what keeps x0 at zero.
  for (genvar k = 0; k < NR_REG_P; k++) begin : g_lut
    localparam logic [NR_REG_P-1:0] ONEHOT_K =
      (k == 0) ? '0 : ({{(NR_REG_P-1){1'b0}}, 1'b1} << k);
    assign lut[(NR_REG_P-1-k)*PAIR_LEN +: PAIR_LEN] = {REG_SEL_P'(k), ONEHOT_K};
  end

  ysyx_22050039_MuxKey #(
    .NR_KEY  (NR_REG_P),
    .KEY_LEN (REG_SEL_P),
    .DATA_LEN(NR_REG_P)
  ) u_wr_dec (
    .out(onehot),
    .key(rd),
    .lut(lut)
  );

  assign unused_onehot0 = onehot[0];

  ysyx_22050039_Reg #(
    .WIDTH    (XLEN_P),
    .RESET_VAL(RESET_VAL_P)
  ) u_reg_x0 (
    .clk (clk),
    .rst (rst),
    .din (wdata),
    .dout(regs[0]),
    .wen (1'b0)
  );

  for (genvar i = 1; i < NR_REG_P; i++) begin : g_reg
    ysyx_22050039_Reg #(
      .WIDTH    (XLEN_P),
      .RESET_VAL(RESET_VAL_P)
    ) u_reg (
      .clk (clk),
      .rst (rst),
      .din (wdata),
      .dout(regs[i]),
      .wen (wen & onehot[i])
    );
  end

  for (genvar i = 0; i < NR_REG_P; i++) begin : g_flat
    assign gprs[i*XLEN_P +: XLEN_P] = regs[i];
  end

  assign rdata1 = regs[rs1];
  assign rdata2 = regs[rs2];
endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: reset, write/read, x0, enable gating, no bypass, sweep.
module tb_gpr_file;
  logic          clk = 1'b0;
  logic          rst;
  logic          wen;
  logic [4:0]    rd;
  logic [63:0]   wdata;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [63:0]   rdata1;
  logic [63:0]   rdata2;
  logic [2047:0] gprs;

  int checks   = 0;
  int failures = 0;

  gpr_file dut (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .rd    (rd),
    .wdata (wdata),
    .rs1   (rs1),
    .rs2   (rs2),
    .rdata1(rdata1),
    .rdata2(rdata2),
    .gprs  (gprs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    assert (gprs === '0) else begin
      failures++;
      $error("FAIL %s observed_nonzero_gprs expected=all_zero", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wen = 1'b1; rd = 5'd5; wdata = 64'hFF; rs1 = 5'd5; rs2 = 5'd0;
    step();
    rst = 1'b0; wen = 1'b0;
    #1;
    check_all_zero("reset_gprs");
    check("reset_rdata1_x5", rdata1, 64'h0);
    check("reset_rdata2_x0", rdata2, 64'h0);

    // basic write/read
    rs1 = 5'd3; wen = 1'b1; rd = 5'd3; wdata = 64'hDEADBEEF_12345678;
    #1;
    check("basic_before_edge", rdata1, 64'h0);
    step();
    wen = 1'b0;
    #1;
    check("basic_after_edge", rdata1, 64'hDEADBEEF_12345678);
    check("basic_gprs_slice3", gprs[3*64 +: 64], 64'hDEADBEEF_12345678);

    // x0 immutability
    wen = 1'b1; rd = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF; rs1 = 5'd0;
    step();
    wen = 1'b0;
    #1;
    check("x0_rdata1", rdata1, 64'h0);
    check("x0_gprs_slice0", gprs[63:0], 64'h0);
    check("x0_write_no_side_x3", gprs[3*64 +: 64], 64'hDEADBEEF_12345678);

    // enable gating
    wen = 1'b0; rd = 5'd7; wdata = 64'h55; rs1 = 5'd7; rs2 = 5'd3;
    step();
    check("wen0_x7_held", rdata1, 64'h0);
    wen = 1'b1;
    step();
    wen = 1'b0;
    #1;
    check("wen1_x7_written", rdata1, 64'h55);
    check("wen1_x3_unchanged", rdata2, 64'hDEADBEEF_12345678);
    check("wen1_x6_unchanged", gprs[6*64 +: 64], 64'h0);
    check("wen1_x8_unchanged", gprs[8*64 +: 64], 64'h0);

    // no bypass, dual read of the same index
    wen = 1'b1; rd = 5'd10; wdata = 64'hA; rs1 = 5'd10; rs2 = 5'd10;
    #1;
    check("nobypass_rdata1_old", rdata1, 64'h0);
    check("nobypass_rdata2_old", rdata2, 64'h0);
    step();
    wen = 1'b0;
    #1;
    check("dual_rdata1_new", rdata1, 64'hA);
    check("dual_rdata2_new", rdata2, 64'hA);

    // one-hot sweep over every writable register
    for (int i = 1; i < 32; i++) begin
      wen = 1'b1; rd = 5'(i); wdata = 64'(i + 100);
      step();
    end
    wen = 1'b0;
    #1;
    check("sweep_slice0", gprs[63:0], 64'h0);
    for (int i = 1; i < 32; i++) begin
      check($sformatf("sweep_slice%0d", i), gprs[i*64 +: 64], 64'(i + 100));
    end
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_rdata1_x%0d", i), rdata1, (i == 0) ? 64'h0 : 64'(i + 100));
      check($sformatf("sweep_rdata2_x%0d", 31 - i), rdata2,
            (i == 31) ? 64'h0 : 64'(31 - i + 100));
    end

    // reset mid-sequence beats a simultaneous write
    rst = 1'b1; wen = 1'b1; rd = 5'd4; wdata = 64'h77; rs1 = 5'd4; rs2 = 5'd31;
    step();
    rst = 1'b0; wen = 1'b0;
    #1;
    check_all_zero("midreset_gprs");
    check("midreset_rdata1_x4", rdata1, 64'h0);
    check("midreset_rdata2_x31", rdata2, 64'h0);

    // registers are writable again after reset
    wen = 1'b1; rd = 5'd31; wdata = 64'h1234;
    step();
    wen = 1'b0;
    #1;
    check("post_reset_write_x31", rdata2, 64'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
